mips_controller: RTL and testbench
==================================

# mips_controller

Multicycle control FSM for the 8-bit MIPS datapath: sequences the four-byte instruction fetch, decodes opcode/funct, and drives every datapath select and write-enable each cycle. Sits directly upstream of the datapath; consumes its `instr[31:26]`, `instr[5:0]` and `zero`, produces all of its control inputs plus memory read/write strobes.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `op`  in  6  opcode, `instr[31:26]`
- `funct`  in  6  function field, `instr[5:0]`
- `zero`  in  1  ALU-result-is-zero from datapath
- `alucontrol`  out  3  add=010, sub=110, and=000, or=001, slt=111
- `alusrca`  out  1  0=register A, 1=PC
- `alusrcb`  out  2  00=register B, 01=constant 1, 10=`instr[7:0]`, 11=constx4
- `iord`  out  1  0=ALUOut drives address, 1=PC drives address
- `irwrite`  out  4  one-hot byte enable; bit 3 loads `instr[31:24]`, bit 0 loads `instr[7:0]`
- `memread`, `memwrite`  out  1 each  memory strobes
- `memtoreg`  out  1  0=memory data register, 1=ALUOut
- `regdst`  out  1  0=rd `instr[13:11]`, 1=rt `instr[18:16]`
- `regwrite`  out  1  register-file write enable
- `pcsource`  out  2  00=ALU result, 01=ALUOut, 10=constx4
- `pcen`  out  1  PC write enable
- `illegal`  out  1  one-cycle pulse on unsupported opcode
- `state`  out  4  current state code (debug)

## Operation
- State register only sequential element; all outputs decoded combinationally from `state` (plus `funct` in RTYPEEX, `zero` in BEQEX). Unlisted outputs are 0 in each state.
- Codes: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14; 15 unused, recovers to FETCH1.
- FETCHn (n=1..4): memread=1, iord=1, irwrite=1<<(4-n), alusrca=1, alusrcb=01, add, pcsource=00, pcen=1. FETCHn -> FETCHn+1; FETCH4 -> DECODE.
- DECODE: alusrca=1, alusrcb=11, add (branch target into ALUOut). Next by `op`: 100000 LB / 101000 SB -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000010 -> JEX; 001000 -> ADDIEX; other -> FETCH1 with illegal=1.
- MEMADR: alusrca=0, alusrcb=10, add. op=100000 -> LBRD, else -> SBWR.
- LBRD: memread=1, iord=0 -> LBWR. LBWR: regwrite=1, regdst=1, memtoreg=0 -> FETCH1.
- SBWR: memwrite=1, iord=0 -> FETCH1.
- RTYPEEX: alusrca=0, alusrcb=00; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other add -> RTYPEWR. RTYPEWR: regwrite=1, regdst=0, memtoreg=1 -> FETCH1.
- BEQEX: alusrca=0, alusrcb=00, sub, pcsource=01, pcen=`zero` -> FETCH1.
- JEX: pcsource=10, pcen=1 -> FETCH1.
- ADDIEX: alusrca=0, alusrcb=10, add -> ADDIWR. ADDIWR: regwrite=1, regdst=1, memtoreg=1 -> FETCH1.

## Timing
- reset low at a rising edge: state <= FETCH1. While reset low, pcen, irwrite, regwrite, memwrite, memread, illegal forced 0 combinationally; others decode FETCH1 (alusrca=1, alusrcb=01, iord=1, alucontrol=010, pcsource=00).
- Reset mid-instruction: abandons it at the next edge; no write strobe asserted in the reset cycle.
- Cycles per instruction: LB 8, SB 7, R-type 7, BEQ 6, J 6, ADDI 7, illegal 5.
- One state per cycle; no stalls, no wait states; memory assumed single-cycle.
- `zero` sampled only in BEQEX, combinationally; must be settled before the edge.

## Configuration
- `MIPS_CTRL_ADDI_EN` defined: ADDIEX/ADDIWR exist; op 001000 decoded as above.
- Undefined: op 001000 is illegal (DECODE -> FETCH1, illegal=1); codes 13/14 treated as unused and recover to FETCH1.

## Test plan
- Reset: hold reset=0 two cycles from arbitrary state -> state=0, pcen=irwrite=regwrite=memwrite=0; release -> irwrite sequence 1000,0100,0010,0001 with pcen=1 each cycle, then state=4.
- R-type: op=000000, funct=100010 -> RTYPEEX alucontrol=110, then RTYPEWR regwrite=1, regdst=0, memtoreg=1; back at FETCH1 after 7 cycles.
- LB then SB: op=100000 -> states 5,6,7 with LBRD memread=1 iord=0, LBWR regwrite=1 regdst=1 memtoreg=0; op=101000 -> 5,8 with memwrite=1 for exactly one cycle.
- BEQ: op=000100 with zero=1 -> pcen=1, pcsource=01 in BEQEX; repeat with zero=0 -> pcen=0.
- J and illegal: op=000010 -> JEX pcsource=10, pcen=1; op=111111 -> illegal=1 for one cycle in DECODE, next state 0, no write strobes.
- ADDI both builds: op=001000 -> with macro, states 13,14 and regwrite=1 regdst=1 memtoreg=1; without macro, illegal=1 and return to FETCH1.

Source files
------------

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: 4-byte fetch, decode, per-state control strobes.
// Optional ADDI support when MIPS_CTRL_ADDI_EN is defined; all outputs decode combinationally from state.
module mips_controller (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    output logic [2:0] alucontrol_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic       iord_o,
    output logic [3:0] irwrite_o,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic       regwrite_o,
    output logic [1:0] pcsource_o,
    output logic       pcen_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;
    state_t dec_state;
    logic   op_legal;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        op_legal = 1'b0;
        case (op_i)
            OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI:                              op_legal = 1'b1;
`endif
            default:                              op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH1;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_FETCH4;
            S_FETCH4: state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_FETCH1;
                endcase
            end
            S_MEMADR:  state_d = (op_i == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    state_d = S_LBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWR;
`endif
            default:   state_d = S_FETCH1;
        endcase
    end

    // In reset, outputs decode as FETCH1 but every strobe is held low.
    assign dec_state = reset_i ? state_q : S_FETCH1;

    always_comb begin
        alucontrol_o = 3'b000;
        alusrca_o    = 1'b0;
        alusrcb_o    = 2'b00;
        iord_o       = 1'b0;
        irwrite_o    = 4'b0000;
        memread_o    = 1'b0;
        memwrite_o   = 1'b0;
        memtoreg_o   = 1'b0;
        regdst_o     = 1'b0;
        regwrite_o   = 1'b0;
        pcsource_o   = 2'b00;
        pcen_o       = 1'b0;
        illegal_o    = 1'b0;
        case (dec_state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                memread_o    = 1'b1;
                iord_o       = 1'b1;
                irwrite_o    = 4'b1000 >> dec_state[1:0];
                alusrca_o    = 1'b1;
                alusrcb_o    = 2'b01;
                alucontrol_o = ALU_ADD;
                pcen_o       = 1'b1;
            end
            S_DECODE: begin
                alusrca_o    = 1'b1;
                alusrcb_o    = 2'b11;
                alucontrol_o = ALU_ADD;
                illegal_o    = !op_legal;
            end
            S_MEMADR: begin
                alusrcb_o    = 2'b10;
                alucontrol_o = ALU_ADD;
            end
            S_LBRD: memread_o = 1'b1;
            S_LBWR: begin
                regwrite_o = 1'b1;
                regdst_o   = 1'b1;
            end
            S_SBWR: memwrite_o = 1'b1;
            S_RTYPEEX: begin
                case (funct_i)
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            S_RTYPEWR: begin
                regwrite_o = 1'b1;
                memtoreg_o = 1'b1;
            end
            S_BEQEX: begin
                alucontrol_o = ALU_SUB;
                pcsource_o   = 2'b01;
                pcen_o       = zero_i;
            end
            S_JEX: begin
                pcsource_o = 2'b10;
                pcen_o     = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEX: begin
                alusrcb_o    = 2'b10;
                alucontrol_o = ALU_ADD;
            end
            S_ADDIWR: begin
                regwrite_o = 1'b1;
                regdst_o   = 1'b1;
                memtoreg_o = 1'b1;
            end
`endif
            default: ;
        endcase
        if (!reset_i) begin
            pcen_o     = 1'b0;
            irwrite_o  = 4'b0000;
            regwrite_o = 1'b0;
            memwrite_o = 1'b0;
            memread_o  = 1'b0;
            illegal_o  = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: vector table, reset corner sequences, random instruction stream vs reference model.
module tb_mips_controller;

    typedef struct packed {
        logic [2:0] alu;
        logic       asa;
        logic [1:0] asb;
        logic       iord;
        logic [3:0] irw;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       rd;
        logic       rw;
        logic [1:0] pcs;
        logic       pcen;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        string      name;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic [3:0] irwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       pcen;
    logic       illegal;
    logic [3:0] state;
    ctl_t       dut_ctl;

    int   checks = 0;
    int   errors = 0;
    ctl_t base [16];
    vec_t vecs [14];

    mips_controller dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .op_i         (op),
        .funct_i      (funct),
        .zero_i       (zero),
        .alucontrol_o (alucontrol),
        .alusrca_o    (alusrca),
        .alusrcb_o    (alusrcb),
        .iord_o       (iord),
        .irwrite_o    (irwrite),
        .memread_o    (memread),
        .memwrite_o   (memwrite),
        .memtoreg_o   (memtoreg),
        .regdst_o     (regdst),
        .regwrite_o   (regwrite),
        .pcsource_o   (pcsource),
        .pcen_o       (pcen),
        .illegal_o    (illegal),
        .state_o      (state)
    );

    assign dut_ctl = {alucontrol, alusrca, alusrcb, iord, irwrite, memread, memwrite,
                      memtoreg, regdst, regwrite, pcsource, pcen, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic ctl_t mk(input logic [2:0] alu, input logic asa, input logic [1:0] asb,
                                input logic io, input logic [3:0] irw, input logic mr,
                                input logic mw, input logic m2r, input logic rd, input logic rw,
                                input logic [1:0] pcs, input logic pe);
        ctl_t c;
        c = {alu, asa, asb, io, irw, mr, mw, m2r, rd, rw, pcs, pe, 1'b0};
        return c;
    endfunction

    function automatic bit addi_en();
`ifdef MIPS_CTRL_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Instruction-level view: the sequence of states each opcode walks through.
    function automatic void build_path(input logic [5:0] o, output int p [12], output int n);
        for (int i = 0; i < 12; i++) p[i] = 0;
        for (int i = 0; i < 5; i++) p[i] = i;
        n = 5;
        if (o == 6'b100000) begin p[5] = 5; p[6] = 6; p[7] = 7; n = 8; end
        else if (o == 6'b101000) begin p[5] = 5; p[6] = 8; n = 7; end
        else if (o == 6'b000000) begin p[5] = 9; p[6] = 10; n = 7; end
        else if (o == 6'b000100) begin p[5] = 11; n = 6; end
        else if (o == 6'b000010) begin p[5] = 12; n = 6; end
        else if (o == 6'b001000 && addi_en()) begin p[5] = 13; p[6] = 14; n = 7; end
    endfunction

    function automatic ctl_t exp_ctl(input int s, input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input logic rst_n);
        ctl_t c;
        int   p [12];
        int   n;
        if (!rst_n) begin
            c = base[0];
            c.irw = 4'b0000; c.mr = 1'b0; c.mw = 1'b0; c.rw = 1'b0; c.pcen = 1'b0; c.ill = 1'b0;
            return c;
        end
        c = base[s];
        if (s == 9) begin
            case (f)
                6'b100010: c.alu = 3'b110;
                6'b100100: c.alu = 3'b000;
                6'b100101: c.alu = 3'b001;
                6'b101010: c.alu = 3'b111;
                default:   c.alu = 3'b010;
            endcase
        end
        if (s == 11) c.pcen = z;
        if (s == 4) begin
            build_path(o, p, n);
            c.ill = (n == 5);
        end
        return c;
    endfunction

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    // Entry: just after a rising edge, DUT in FETCH1, reset high.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int exp_cycles, input string nm);
        int   p [12];
        int   n;
        int   cyc;
        int   mw_cnt;
        int   rw_cnt;
        int   exp_s;
        int   exp_mw;
        int   exp_rw;
        ctl_t e;
        build_path(o, p, n);
        op = o; funct = f; zero = z;
        cyc = 0; mw_cnt = 0; rw_cnt = 0;
        do begin
            #1;
            exp_s = (cyc < n) ? p[cyc] : 0;
            e = exp_ctl(exp_s, o, f, z, 1'b1);
            chk(state == exp_s[3:0], {nm, " state"}, int'(state), exp_s);
            chk(dut_ctl == e, {nm, " ctl"}, int'(dut_ctl), int'(e));
            mw_cnt += int'(memwrite);
            rw_cnt += int'(regwrite);
            @(posedge clk);
            #1;
            cyc++;
        end while (state != 4'd0 && cyc < 12);
        exp_mw = (o == 6'b101000) ? 1 : 0;
        exp_rw = (o == 6'b100000 || o == 6'b000000 || (o == 6'b001000 && addi_en())) ? 1 : 0;
        chk(cyc == exp_cycles, {nm, " cycles"}, cyc, exp_cycles);
        chk(mw_cnt == exp_mw, {nm, " memwrite_count"}, mw_cnt, exp_mw);
        chk(rw_cnt == exp_rw, {nm, " regwrite_count"}, rw_cnt, exp_rw);
    endtask

    task automatic mid_reset(input logic [5:0] o, input int steps, input int exp_s, input string nm);
        ctl_t e;
        op = o; funct = 6'b100000; zero = 1'b0;
        repeat (steps) @(posedge clk);
        #1;
        chk(state == exp_s[3:0], {nm, " pre_state"}, int'(state), exp_s);
        reset = 1'b0;
        #1;
        e = exp_ctl(0, o, funct, zero, 1'b0);
        chk(dut_ctl == e, {nm, " reset_ctl"}, int'(dut_ctl), int'(e));
        chk(state == exp_s[3:0], {nm, " held_state"}, int'(state), exp_s);
        @(posedge clk);
        #1;
        chk(state == 4'd0, {nm, " post_state"}, int'(state), 0);
        reset = 1'b1;
    endtask

    initial begin
        ctl_t e;
        logic [3:0] exp_irw;
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        logic [5:0] ro;
        logic [5:0] rf;
        int p [12];
        int n;

        for (int i = 0; i < 4; i++)
            base[i] = mk(3'b010, 1'b1, 2'b01, 1'b1, 4'b1000 >> i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        base[4]  = mk(3'b010, 1'b1, 2'b11, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        base[5]  = mk(3'b010, 1'b0, 2'b10, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        base[6]  = mk(3'b000, 1'b0, 2'b00, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        base[7]  = mk(3'b000, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
        base[8]  = mk(3'b000, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        base[9]  = mk(3'b000, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        base[10] = mk(3'b000, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        base[11] = mk(3'b110, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        base[12] = mk(3'b000, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
        base[13] = '0;
        base[14] = '0;
        base[15] = '0;
        if (addi_en()) begin
            base[13] = mk(3'b010, 1'b0, 2'b10, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
            base[14] = mk(3'b000, 1'b0, 2'b00, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        end

        vecs[0]  = '{6'b000000, 6'b100010, 1'b0, 7, "rtype_sub"};
        vecs[1]  = '{6'b000000, 6'b100000, 1'b1, 7, "rtype_add"};
        vecs[2]  = '{6'b000000, 6'b100100, 1'b0, 7, "rtype_and"};
        vecs[3]  = '{6'b000000, 6'b100101, 1'b0, 7, "rtype_or"};
        vecs[4]  = '{6'b000000, 6'b101010, 1'b0, 7, "rtype_slt"};
        vecs[5]  = '{6'b000000, 6'b000111, 1'b0, 7, "rtype_other"};
        vecs[6]  = '{6'b100000, 6'b000000, 1'b0, 8, "lb"};
        vecs[7]  = '{6'b101000, 6'b000000, 1'b0, 7, "sb"};
        vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 6, "beq_taken"};
        vecs[9]  = '{6'b000100, 6'b000000, 1'b0, 6, "beq_not_taken"};
        vecs[10] = '{6'b000010, 6'b000000, 1'b0, 6, "j"};
        vecs[11] = '{6'b111111, 6'b000000, 1'b0, 5, "illegal_3f"};
        vecs[12] = '{6'b001000, 6'b000000, 1'b0, addi_en() ? 7 : 5, "addi"};
        vecs[13] = '{6'b100001, 6'b100000, 1'b1, 5, "illegal_21"};

        // Power-up reset from an arbitrary state.
        reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(state == 4'd0, "reset state", int'(state), 0);
        e = exp_ctl(0, op, funct, zero, 1'b0);
        chk(dut_ctl == e, "reset ctl", int'(dut_ctl), int'(e));
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_irw = 4'b1000 >> i;
            chk(irwrite == exp_irw, "fetch irwrite", int'(irwrite), int'(exp_irw));
            chk(pcen == 1'b1, "fetch pcen", int'(pcen), 1);
            @(posedge clk);
            #1;
        end
        chk(state == 4'd4, "after fetch state", int'(state), 4);
        // Reset landing in DECODE with an illegal opcode: no illegal pulse.
        op = 6'b111111;
        reset = 1'b0;
        #1;
        chk(illegal == 1'b0, "reset suppresses illegal", int'(illegal), 0);
        @(posedge clk);
        #1;
        chk(state == 4'd0, "decode reset state", int'(state), 0);
        reset = 1'b1;

        foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].cycles, vecs[i].name);

        mid_reset(6'b101000, 6, 8, "reset_in_sbwr");
        mid_reset(6'b100000, 7, 7, "reset_in_lbwr");
        mid_reset(6'b000000, 6, 10, "reset_in_rtypewr");
        mid_reset(6'b000010, 2, 2, "reset_in_fetch3");

        ops = '{6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int k = 0; k < 300; k++) begin
            ro = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            build_path(ro, p, n);
            run_instr(ro, rf, 1'($urandom), n, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
